// File: rtl/z_event_logger.sv
// z_event_logger: timestamps Z1/Z2 detector pulses, keeps saturating per-type
// counts and buffers {type, timestamp} records in a show-ahead FIFO drained by
// a valid/ready stream.
//
// state  | meaning
// -------+-----------------------------------------------
// EMPTY  | no record buffered, ev_valid low
// ACTIVE | 1..DEPTH-1 records buffered, head presented
// FULL   | DEPTH records buffered, pushes need a same-cycle pop
module z_event_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     Z1,
    input  logic                     Z2,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic                     ev_type,
    output logic [TS_W-1:0]          ev_time,
    output logic [CNT_W-1:0]         cnt1,
    output logic [CNT_W-1:0]         cnt2,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     err_both
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int REC_W = TS_W + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [TS_W-1:0]  ts_q,     ts_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic [CNT_W-1:0] cnt1_q,   cnt1_d;
    logic [CNT_W-1:0] cnt2_q,   cnt2_d;
    logic             ovf_q,    ovf_d;
    logic             both_q,   both_d;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] head_w;

    logic event_w;
    logic pop_w;
    logic push_w;

    // Handshake decode: a full FIFO still accepts a record if the head leaves this cycle.
    always_comb begin
        event_w = Z1 | Z2;
        pop_w   = (state_q != ST_EMPTY) & ev_ready & ~clr;
        push_w  = event_w & ~clr & ((level_q != LVL_FULL) | pop_w);
    end

    // Datapath next-state: timestamp, pointers, occupancy, counters, sticky flags.
    always_comb begin
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        ovf_d    = ovf_q;
        both_d   = both_q;
        if (clr) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt1_d   = '0;
            cnt2_d   = '0;
            ovf_d    = 1'b0;
            both_d   = 1'b0;
        end else begin
            ts_d = ts_q + TS_W'(1);
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_w && !pop_w) begin
                level_d = level_q + LW'(1);
            end else if (pop_w && !push_w) begin
                level_d = level_q - LW'(1);
            end
            if (Z1 && (cnt1_q != '1)) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
            if (Z2 && (cnt2_q != '1)) begin
                cnt2_d = cnt2_q + CNT_W'(1);
            end
            // Counters still count a dropped record; only the FIFO entry is lost.
            if (event_w && !push_w) begin
                ovf_d = 1'b1;
            end
            if (Z1 && Z2) begin
                both_d = 1'b1;
            end
        end
    end

    // FIFO state machine, steered by the occupancy after this cycle's update.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_w) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (level_d == LVL_FULL) begin
                        state_d = ST_FULL;
                    end else if (level_d == '0) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (level_d != LVL_FULL) begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            ovf_q    <= 1'b0;
            both_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            ovf_q    <= ovf_d;
            both_q   <= both_d;
        end
    end

    // Record storage; Z2 wins the type bit when both pulses coincide.
    // When full with a same-cycle pop, wr_ptr equals rd_ptr and the slot being
    // vacated is rewritten at the edge, after the head has been consumed.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= {Z2, ts_q};
        end
    end

    // Stale memory contents are masked so the head reads zero while empty.
    always_comb begin
        head_w   = mem_q[rd_ptr_q];
        ev_valid = (state_q != ST_EMPTY);
        ev_type  = ev_valid & head_w[TS_W];
        ev_time  = ev_valid ? head_w[TS_W-1:0] : '0;
        cnt1     = cnt1_q;
        cnt2     = cnt2_q;
        level    = level_q;
        overflow = ovf_q;
        err_both = both_q;
    end

endmodule
